ex_mem_reg: RTL and testbench

- Dual-lane pipeline register between the EX stage (dual ALU functional unit) and the MEM stage.
- Captures the lane A/B ALU results together with PC, writeback control and memory-op control.
- Applies EX branch-resolution kill of lane B, a valid/ready handshake with MEM, and pipeline flush.
- Drives registered forwarding data back to the EX operand muxes.

---
 rtl/ex_mem_reg_pkg.sv | 27 ++
 rtl/ex_mem_lane.sv | 73 +++++++
 rtl/ex_mem_reg.sv | 124 ++++++++++++
 tb/tb_ex_mem_reg.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_mem_reg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ex_mem_reg_pkg
// Description : Shared widths, constants and lane record for the EX/MEM register.
// Revision    : 1.0 - initial release
// ============================================================================
package ex_mem_reg_pkg;

    localparam int DATA_W     = 32;
    localparam int REG_W      = 5;
    localparam int MEMOP_W    = 4;
    localparam int KILL_CNT_W = 16;

    localparam logic [MEMOP_W-1:0] MEM_OP_NONE = '0;

    typedef struct packed {
        logic               valid;
        logic [DATA_W-1:0]  pc;
        logic [DATA_W-1:0]  alu_result;
        logic [DATA_W-1:0]  st_data;
        logic               rf_we;
        logic [REG_W-1:0]   rf_waddr;
        logic [MEMOP_W-1:0] mem_op;
    } lane_t;

endpackage
`default_nettype wire

// File: rtl/ex_mem_lane.sv
`default_nettype none
// ============================================================================
// Module      : ex_mem_lane
// Description : One lane of the EX/MEM register with load, hold and kill.
// Revision    : 1.0 - initial release
// ============================================================================
module ex_mem_lane #(
    parameter int DATA_W  = ex_mem_reg_pkg::DATA_W,
    parameter int REG_W   = ex_mem_reg_pkg::REG_W,
    parameter int MEMOP_W = ex_mem_reg_pkg::MEMOP_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_load,
    input  logic               i_kill,
    input  logic               i_valid,
    input  logic [DATA_W-1:0]  i_pc,
    input  logic [DATA_W-1:0]  i_alu_result,
    input  logic [DATA_W-1:0]  i_st_data,
    input  logic               i_rf_we,
    input  logic [REG_W-1:0]   i_rf_waddr,
    input  logic [MEMOP_W-1:0] i_mem_op,
    output logic               o_valid,
    output logic [DATA_W-1:0]  o_pc,
    output logic [DATA_W-1:0]  o_alu_result,
    output logic [DATA_W-1:0]  o_st_data,
    output logic               o_rf_we,
    output logic [REG_W-1:0]   o_rf_waddr,
    output logic [MEMOP_W-1:0] o_mem_op
);
    import ex_mem_reg_pkg::*;

    logic               r_valid;
    logic [DATA_W-1:0]  r_pc;
    logic [DATA_W-1:0]  r_alu_result;
    logic [DATA_W-1:0]  r_st_data;
    logic               r_rf_we;
    logic [REG_W-1:0]   r_rf_waddr;
    logic [MEMOP_W-1:0] r_mem_op;

    // Kill only drops the valid bit; the payload is don't-care once invalid.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid      <= 1'b0;
            r_pc         <= '0;
            r_alu_result <= '0;
            r_st_data    <= '0;
            r_rf_we      <= 1'b0;
            r_rf_waddr   <= '0;
            r_mem_op     <= MEMOP_W'(MEM_OP_NONE);
        end else if (i_kill) begin
            r_valid      <= 1'b0;
        end else if (i_load) begin
            r_valid      <= i_valid;
            r_pc         <= i_pc;
            r_alu_result <= i_alu_result;
            r_st_data    <= i_st_data;
            r_rf_we      <= i_rf_we;
            r_rf_waddr   <= i_rf_waddr;
            r_mem_op     <= i_mem_op;
        end
    end

    assign o_valid      = r_valid;
    assign o_pc         = r_pc;
    assign o_alu_result = r_alu_result;
    assign o_st_data    = r_st_data;
    assign o_rf_we      = r_rf_we & r_valid;
    assign o_rf_waddr   = r_rf_waddr;
    assign o_mem_op     = r_mem_op;

endmodule
`default_nettype wire

// File: rtl/ex_mem_reg.sv
`default_nettype none
// ============================================================================
// Module      : ex_mem_reg
// Description : Dual-lane EX/MEM pipeline register with handshake, flush and lane-B kill.
// Revision    : 1.0 - initial release
// ============================================================================
module ex_mem_reg #(
    parameter int DATA_W  = ex_mem_reg_pkg::DATA_W,
    parameter int REG_W   = ex_mem_reg_pkg::REG_W,
    parameter int MEMOP_W = ex_mem_reg_pkg::MEMOP_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               EX_valid_a,
    input  logic               EX_valid_b,
    input  logic [DATA_W-1:0]  EX_pc_a,
    input  logic [DATA_W-1:0]  EX_pc_b,
    input  logic [DATA_W-1:0]  EX_alu_result_a,
    input  logic [DATA_W-1:0]  EX_alu_result_b,
    input  logic [DATA_W-1:0]  EX_st_data_a,
    input  logic [DATA_W-1:0]  EX_st_data_b,
    input  logic               EX_rf_we_a,
    input  logic               EX_rf_we_b,
    input  logic [REG_W-1:0]   EX_rf_waddr_a,
    input  logic [REG_W-1:0]   EX_rf_waddr_b,
    input  logic [MEMOP_W-1:0] EX_mem_op_a,
    input  logic [MEMOP_W-1:0] EX_mem_op_b,
    input  logic               EX_br,
    input  logic               EX_br_lane,
    output logic               EX_ready,
    input  logic               MEM_ready,
    input  logic               flush,
    output logic               MEM_valid_a,
    output logic               MEM_valid_b,
    output logic [DATA_W-1:0]  MEM_pc_a,
    output logic [DATA_W-1:0]  MEM_pc_b,
    output logic [DATA_W-1:0]  MEM_alu_result_a,
    output logic [DATA_W-1:0]  MEM_alu_result_b,
    output logic [DATA_W-1:0]  MEM_st_data_a,
    output logic [DATA_W-1:0]  MEM_st_data_b,
    output logic               MEM_rf_we_a,
    output logic               MEM_rf_we_b,
    output logic [REG_W-1:0]   MEM_rf_waddr_a,
    output logic [REG_W-1:0]   MEM_rf_waddr_b,
    output logic [MEMOP_W-1:0] MEM_mem_op_a,
    output logic [MEMOP_W-1:0] MEM_mem_op_b,
    output logic [15:0]        kill_cnt
);
    import ex_mem_reg_pkg::*;

    logic                  w_capture;
    logic                  w_kill_b;
    logic                  w_valid_b_in;
    logic [KILL_CNT_W-1:0] r_kill_cnt;

    // Ready depends only on held state and MEM_ready so EX never sees a loop.
    assign EX_ready     = ~(MEM_valid_a | MEM_valid_b) | MEM_ready;
    assign w_capture    = EX_ready & ~flush;
    assign w_kill_b     = EX_br & ~EX_br_lane;
    assign w_valid_b_in = EX_valid_b & ~w_kill_b;

    ex_mem_lane #(
        .DATA_W  (DATA_W),
        .REG_W   (REG_W),
        .MEMOP_W (MEMOP_W)
    ) u_lane_a (
        .clk          (clk),
        .rst          (rst),
        .i_load       (w_capture),
        .i_kill       (flush),
        .i_valid      (EX_valid_a),
        .i_pc         (EX_pc_a),
        .i_alu_result (EX_alu_result_a),
        .i_st_data    (EX_st_data_a),
        .i_rf_we      (EX_rf_we_a),
        .i_rf_waddr   (EX_rf_waddr_a),
        .i_mem_op     (EX_mem_op_a),
        .o_valid      (MEM_valid_a),
        .o_pc         (MEM_pc_a),
        .o_alu_result (MEM_alu_result_a),
        .o_st_data    (MEM_st_data_a),
        .o_rf_we      (MEM_rf_we_a),
        .o_rf_waddr   (MEM_rf_waddr_a),
        .o_mem_op     (MEM_mem_op_a)
    );

    ex_mem_lane #(
        .DATA_W  (DATA_W),
        .REG_W   (REG_W),
        .MEMOP_W (MEMOP_W)
    ) u_lane_b (
        .clk          (clk),
        .rst          (rst),
        .i_load       (w_capture),
        .i_kill       (flush),
        .i_valid      (w_valid_b_in),
        .i_pc         (EX_pc_b),
        .i_alu_result (EX_alu_result_b),
        .i_st_data    (EX_st_data_b),
        .i_rf_we      (EX_rf_we_b),
        .i_rf_waddr   (EX_rf_waddr_b),
        .i_mem_op     (EX_mem_op_b),
        .o_valid      (MEM_valid_b),
        .o_pc         (MEM_pc_b),
        .o_alu_result (MEM_alu_result_b),
        .o_st_data    (MEM_st_data_b),
        .o_rf_we      (MEM_rf_we_b),
        .o_rf_waddr   (MEM_rf_waddr_b),
        .o_mem_op     (MEM_mem_op_b)
    );

    // Counts only lane-B instructions that were real and actually squashed.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_kill_cnt <= '0;
        end else if (w_capture && EX_valid_b && w_kill_b && (r_kill_cnt != '1)) begin
            r_kill_cnt <= r_kill_cnt + KILL_CNT_W'(1);
        end
    end

    assign kill_cnt = r_kill_cnt;

endmodule
`default_nettype wire

// File: tb/tb_ex_mem_reg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_ex_mem_reg
// Description : Scoreboard bench for ex_mem_reg using directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_mem_reg;
    import ex_mem_reg_pkg::*;

    typedef struct packed {
        int          cyc;
        int          id;
        lane_t       a;
        lane_t       b;
        logic [15:0] kc;
        logic        chk;
    } exp_t;

    typedef struct packed {
        int   cyc;
        int   id;
        logic rdy;
    } rdy_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst, flush, MEM_ready, EX_br, EX_br_lane, EX_ready;
    logic               EX_valid_a, EX_valid_b, EX_rf_we_a, EX_rf_we_b;
    logic [DATA_W-1:0]  EX_pc_a, EX_pc_b, EX_alu_result_a, EX_alu_result_b;
    logic [DATA_W-1:0]  EX_st_data_a, EX_st_data_b;
    logic [REG_W-1:0]   EX_rf_waddr_a, EX_rf_waddr_b;
    logic [MEMOP_W-1:0] EX_mem_op_a, EX_mem_op_b;
    logic               MEM_valid_a, MEM_valid_b, MEM_rf_we_a, MEM_rf_we_b;
    logic [DATA_W-1:0]  MEM_pc_a, MEM_pc_b, MEM_alu_result_a, MEM_alu_result_b;
    logic [DATA_W-1:0]  MEM_st_data_a, MEM_st_data_b;
    logic [REG_W-1:0]   MEM_rf_waddr_a, MEM_rf_waddr_b;
    logic [MEMOP_W-1:0] MEM_mem_op_a, MEM_mem_op_b;
    logic [15:0]        kill_cnt;

    ex_mem_reg dut (
        .clk(clk), .rst(rst),
        .EX_valid_a(EX_valid_a), .EX_valid_b(EX_valid_b),
        .EX_pc_a(EX_pc_a), .EX_pc_b(EX_pc_b),
        .EX_alu_result_a(EX_alu_result_a), .EX_alu_result_b(EX_alu_result_b),
        .EX_st_data_a(EX_st_data_a), .EX_st_data_b(EX_st_data_b),
        .EX_rf_we_a(EX_rf_we_a), .EX_rf_we_b(EX_rf_we_b),
        .EX_rf_waddr_a(EX_rf_waddr_a), .EX_rf_waddr_b(EX_rf_waddr_b),
        .EX_mem_op_a(EX_mem_op_a), .EX_mem_op_b(EX_mem_op_b),
        .EX_br(EX_br), .EX_br_lane(EX_br_lane), .EX_ready(EX_ready),
        .MEM_ready(MEM_ready), .flush(flush),
        .MEM_valid_a(MEM_valid_a), .MEM_valid_b(MEM_valid_b),
        .MEM_pc_a(MEM_pc_a), .MEM_pc_b(MEM_pc_b),
        .MEM_alu_result_a(MEM_alu_result_a), .MEM_alu_result_b(MEM_alu_result_b),
        .MEM_st_data_a(MEM_st_data_a), .MEM_st_data_b(MEM_st_data_b),
        .MEM_rf_we_a(MEM_rf_we_a), .MEM_rf_we_b(MEM_rf_we_b),
        .MEM_rf_waddr_a(MEM_rf_waddr_a), .MEM_rf_waddr_b(MEM_rf_waddr_b),
        .MEM_mem_op_a(MEM_mem_op_a), .MEM_mem_op_b(MEM_mem_op_b),
        .kill_cnt(kill_cnt)
    );

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t st_q[$];
    rdy_t rdy_q[$];
    bit   drv_done = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Lane payload: pc, store data and mem-op are tied to the result so each field is distinct.
    function automatic lane_t mk(input bit lane_b, input logic v, input logic [31:0] res,
                                 input logic we, input logic [4:0] wa);
        lane_t l;
        l.valid      = v;
        l.pc         = res ^ (lane_b ? 32'hB000_0000 : 32'hA000_0000);
        l.alu_result = res;
        l.st_data    = ~res;
        l.rf_we      = we;
        l.rf_waddr   = wa;
        l.mem_op     = res[7:4];
        return l;
    endfunction

    function automatic lane_t killed(input lane_t l);
        lane_t k = l;
        k.valid = 1'b0;
        return k;
    endfunction

    task automatic vec(input int id, input logic r, input logic fl, input logic mr,
                       input logic br, input logic brl, input lane_t a, input lane_t b,
                       input int rdy, input logic chk, input lane_t ea, input lane_t eb,
                       input logic [15:0] kc, input bit push);
        exp_t e;
        rdy_t q;
        @(posedge clk);
        #1;
        rst = r; flush = fl; MEM_ready = mr; EX_br = br; EX_br_lane = brl;
        EX_valid_a = a.valid; EX_pc_a = a.pc; EX_alu_result_a = a.alu_result;
        EX_st_data_a = a.st_data; EX_rf_we_a = a.rf_we; EX_rf_waddr_a = a.rf_waddr;
        EX_mem_op_a = a.mem_op;
        EX_valid_b = b.valid; EX_pc_b = b.pc; EX_alu_result_b = b.alu_result;
        EX_st_data_b = b.st_data; EX_rf_we_b = b.rf_we; EX_rf_waddr_b = b.rf_waddr;
        EX_mem_op_b = b.mem_op;
        if (push) begin
            if (rdy >= 0) begin
                q.cyc = cyc; q.id = id; q.rdy = rdy[0];
                rdy_q.push_back(q);
            end
            e.cyc = cyc + 1; e.id = id; e.a = ea; e.b = eb; e.kc = kc; e.chk = chk;
            e.a.rf_we = ea.rf_we & ea.valid;
            e.b.rf_we = eb.rf_we & eb.valid;
            st_q.push_back(e);
        end
    endtask

    // Monitor: checks whatever expectation is due in the current cycle.
    initial begin
        lane_t act_a, act_b;
        exp_t  e;
        rdy_t  q;
        bit    ok;
        forever begin
            @(negedge clk);
            while (rdy_q.size() > 0 && rdy_q[0].cyc <= cyc) begin
                q = rdy_q.pop_front();
                n_cmp++;
                if (q.cyc != cyc || EX_ready !== q.rdy) begin
                    n_bad++;
                    $display("FAIL ex_ready vec%0d: got %b want %b (cyc %0d due %0d)",
                             q.id, EX_ready, q.rdy, cyc, q.cyc);
                end
            end
            while (st_q.size() > 0 && st_q[0].cyc <= cyc) begin
                e = st_q.pop_front();
                act_a = '{MEM_valid_a, MEM_pc_a, MEM_alu_result_a, MEM_st_data_a,
                          MEM_rf_we_a, MEM_rf_waddr_a, MEM_mem_op_a};
                act_b = '{MEM_valid_b, MEM_pc_b, MEM_alu_result_b, MEM_st_data_b,
                          MEM_rf_we_b, MEM_rf_waddr_b, MEM_mem_op_b};
                ok = (e.cyc == cyc) &&
                     (act_a.valid === e.a.valid) && (act_b.valid === e.b.valid) &&
                     (act_a.rf_we === e.a.rf_we) && (act_b.rf_we === e.b.rf_we) &&
                     (kill_cnt === e.kc) &&
                     (!e.chk || ((act_a === e.a) && (act_b === e.b)));
                n_cmp++;
                if (!ok) begin
                    n_bad++;
                    $display("FAIL state vec%0d: got a=%h b=%h kc=%h want a=%h b=%h kc=%h (data %b)",
                             e.id, act_a, act_b, kill_cnt, e.a, e.b, e.kc, e.chk);
                end
            end
            if (drv_done && st_q.size() == 0 && rdy_q.size() == 0) break;
        end
    end

    initial begin
        #2_000_000;
        n_bad++;
        $display("FAIL watchdog: got timeout want completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "timeout");
    end

    initial begin
        lane_t z, a, b, a2, b2;
        z = '0;
        rst = 1'b1; flush = 1'b0; MEM_ready = 1'b0; EX_br = 1'b0; EX_br_lane = 1'b0;
        EX_valid_a = 1'b0; EX_valid_b = 1'b0; EX_pc_a = '0; EX_pc_b = '0;
        EX_alu_result_a = '0; EX_alu_result_b = '0; EX_st_data_a = '0; EX_st_data_b = '0;
        EX_rf_we_a = 1'b0; EX_rf_we_b = 1'b0; EX_rf_waddr_a = '0; EX_rf_waddr_b = '0;
        EX_mem_op_a = '0; EX_mem_op_b = '0;

        // Reset with random inputs
        vec(1, 1, 0, 0, 0, 0, mk(0, 1, $urandom, 1, 5'($urandom)), mk(1, 1, $urandom, 1, 5'($urandom)),
            -1, 1, z, z, 16'h0, 1);
        vec(2, 1, 0, 0, 1, 0, mk(0, 1, $urandom, 1, 5'($urandom)), mk(1, 1, $urandom, 1, 5'($urandom)),
            1, 1, z, z, 16'h0, 1);

        // Normal capture
        a = mk(0, 1, 32'h0000_1234, 1, 5'd7);
        b = mk(1, 1, 32'hFFFF_FFFC, 1, 5'd8);
        vec(3, 0, 0, 1, 0, 0, a, b, 1, 1, a, b, 16'h0, 1);

        // Stall three cycles while inputs change
        vec(4, 0, 0, 0, 0, 0, mk(0, 1, 32'hAAAA, 0, 5'd9), mk(1, 1, 32'hBBBB, 0, 5'd10),
            0, 1, a, b, 16'h0, 1);
        vec(5, 0, 0, 0, 0, 0, mk(0, 1, 32'hCCCC, 0, 5'd9), mk(1, 0, 32'hBBBB, 0, 5'd10),
            0, 1, a, b, 16'h0, 1);
        vec(6, 0, 0, 0, 1, 0, mk(0, 0, 32'hDDDD, 0, 5'd9), mk(1, 1, 32'hEEEE, 0, 5'd10),
            0, 1, a, b, 16'h0, 1);

        // Release: new data captured
        a = mk(0, 1, 32'h5555, 0, 5'd3);
        b = mk(1, 1, 32'h6666, 1, 5'd4);
        vec(7, 0, 0, 1, 0, 0, a, b, 1, 1, a, b, 16'h0, 1);

        // Lane A branch kills lane B; write enable of B gated, waddr kept
        a = mk(0, 1, 32'h100, 1, 5'd11);
        b = mk(1, 1, 32'h200, 1, 5'd12);
        vec(8, 0, 0, 1, 1, 0, a, b, 1, 1, a, killed(b), 16'h1, 1);

        // Lane B branch kills nothing
        a = mk(0, 1, 32'h300, 1, 5'd13);
        b = mk(1, 1, 32'h400, 1, 5'd14);
        vec(9, 0, 0, 1, 1, 1, a, b, 1, 1, a, b, 16'h1, 1);

        // Flush beats capture and kill
        vec(10, 0, 1, 1, 1, 0, mk(0, 1, 32'h500, 1, 5'd15), mk(1, 1, 32'h600, 1, 5'd16),
            1, 0, z, z, 16'h1, 1);

        // Bubble into empty register; EX_ready high even with MEM_ready low
        a = mk(0, 0, 32'h777, 1, 5'd17);
        b = mk(1, 0, 32'h888, 1, 5'd18);
        vec(11, 0, 0, 0, 0, 0, a, b, 1, 1, a, b, 16'h1, 1);

        // Lane B valid behind a lane A bubble
        a = mk(0, 0, 32'h111, 1, 5'd19);
        b = mk(1, 1, 32'h999, 1, 5'd20);
        vec(12, 0, 0, 0, 0, 0, a, b, 1, 1, a, b, 16'h1, 1);

        // Kill with lane B already invalid leaves the counter alone
        a = mk(0, 1, 32'hABC, 1, 5'd21);
        b = mk(1, 0, 32'hDEF, 1, 5'd22);
        vec(13, 0, 0, 1, 1, 0, a, b, 1, 1, a, b, 16'h1, 1);

        // Kill request during hold is not counted
        a2 = mk(0, 1, 32'h1, 1, 5'd1);
        b2 = mk(1, 1, 32'h2, 1, 5'd2);
        vec(14, 0, 0, 0, 1, 0, a2, b2, 0, 1, a, b, 16'h1, 1);

        // Reset mid-hold
        vec(15, 1, 0, 0, 1, 0, a2, b2, 0, 1, z, z, 16'h0, 1);

        // Kill then simultaneous flush and reset
        vec(16, 0, 0, 1, 1, 0, a2, b2, 1, 1, a2, killed(b2), 16'h1, 1);
        vec(17, 1, 1, 1, 1, 0, a2, b2, 1, 1, z, z, 16'h0, 1);

        // Drive the counter to saturation
        for (int i = 0; i < 65534; i++) begin
            vec(100, 0, 0, 1, 1, 0, a2, b2, 1, 1, a2, killed(b2), 16'h0, 0);
        end
        vec(18, 0, 0, 1, 1, 0, a2, b2, 1, 1, a2, killed(b2), 16'hFFFF, 1);
        vec(19, 0, 0, 1, 1, 0, a2, b2, 1, 1, a2, killed(b2), 16'hFFFF, 1);
        vec(20, 0, 1, 1, 1, 0, a2, b2, 1, 0, z, z, 16'hFFFF, 1);

        a = mk(0, 1, 32'hCAFE, 1, 5'd30);
        b = mk(1, 1, 32'hBEEF, 0, 5'd31);
        vec(21, 0, 0, 1, 0, 0, a, b, 1, 1, a, b, 16'hFFFF, 1);

        drv_done = 1'b1;
        repeat (4) @(posedge clk);
        #2;
        while (st_q.size() > 0) begin
            exp_t e;
            e = st_q.pop_front();
            n_cmp++;
            n_bad++;
            $display("FAIL state vec%0d: got no check want check at cyc %0d", e.id, e.cyc);
        end
        while (rdy_q.size() > 0) begin
            rdy_t q;
            q = rdy_q.pop_front();
            n_cmp++;
            n_bad++;
            $display("FAIL ex_ready vec%0d: got no check want check at cyc %0d", q.id, q.cyc);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
